// File: rtl/flappy_pkg.sv
// flappy_pkg: shared types and constants for the Flappy Bird game controller.
//   game_state_e   - game phase (idle / playing / dead)
//   Def*           - default values of the controller parameters
//   geometry       - bird half-height, gap offsets and ground reference, all in
//                    screen pixels (y grows downwards on screen, bird_coord grows upwards)
package flappy_pkg;

   typedef enum logic [1:0] {StIdle, StPlay, StDead} game_state_e;

   // Default controller parameters
   localparam int unsigned DefPipeSpeed = 2;
   localparam int unsigned DefPipeWrap  = 345;
   localparam int unsigned DefGravity   = 1;
   localparam int unsigned DefFlapVel   = 8;
   localparam int unsigned DefMaxFall   = 10;
   localparam int unsigned DefBirdMin   = 20;
   localparam int unsigned DefBirdMax   = 460;
   localparam int unsigned DefBirdStart = 240;
   localparam int unsigned DefScorePos  = 246;
   localparam int unsigned DefDeadHold  = 60;

   // Geometry. The bird occupies screen x 100..140; pipe0 overlaps that column
   // while pipe_pos is strictly inside HitPosLo..HitPosHi.
   localparam int unsigned BirdHalfH = 20;
   localparam int unsigned GapTopOff = 75;
   localparam int unsigned GapBotOff = 215;
   localparam int unsigned GroundY   = 500;  // 480 + half-height: bottom edge = GroundY - bird
   localparam int unsigned HitPosLo  = 155;
   localparam int unsigned HitPosHi  = 245;

   // Game values
   localparam int unsigned ResetGap = 100;
   localparam int unsigned GapBase  = 40;
   localparam int unsigned ScoreMax = 15;
   localparam logic [7:0]  LfsrSeed = 8'hA5;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// flappy_game_ctrl_if: frame/button inputs and renderer-facing game state.
//   frame_tick    - one-cycle pulse per video frame
//   flap          - one-cycle debounced button pulse
//   bird_coord    - bird centre height above screen bottom
//   pipe_pos      - pipe scroll offset
//   pipe_array0/1 - gap tops of leading / trailing pipe
//   current_score - saturating score
//   game_over     - high while the bird is dead
// master: the frame/button source and renderer; slave: the game controller.
interface flappy_game_ctrl_if;

   logic       frame_tick;
   logic       flap;
   logic [9:0] bird_coord;
   logic [8:0] pipe_pos;
   logic [7:0] pipe_array0;
   logic [7:0] pipe_array1;
   logic [3:0] current_score;
   logic       game_over;

   modport master (
      output frame_tick, flap,
      input  bird_coord, pipe_pos, pipe_array0, pipe_array1, current_score, game_over
   );

   modport slave (
      input  frame_tick, flap,
      output bird_coord, pipe_pos, pipe_array0, pipe_array1, current_score, game_over
   );

endinterface

// File: rtl/flappy_lfsr.sv
// flappy_lfsr: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded on clr.
//   dclk - clock
//   clr  - synchronous active-high reset (loads the seed)
//   rnd  - low 7 bits of the current LFSR state
module flappy_lfsr
   import flappy_pkg::*;
(
   input  logic       dclk,
   input  logic       clr,
   output logic [6:0] rnd
);

   logic [7:0] lfsr_q;
   logic       fb;

   assign fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   assign rnd = lfsr_q[6:0];

   always_ff @(posedge dclk) begin
      if (clr) begin
         lfsr_q <= LfsrSeed;
      end else begin
         lfsr_q <= {lfsr_q[6:0], fb};
      end
   end

endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: per-frame game sequencer for the VGA Flappy Bird display.
//   dclk - 25 MHz pixel clock
//   clr  - synchronous active-high reset
//   bus  - slave side of flappy_game_ctrl_if (frame_tick/flap in, game state out)
// All game state changes on frame_tick only; outputs are registered so an update
// on the tick cycle is visible one cycle later, inside vertical blanking.
module flappy_game_ctrl
   import flappy_pkg::*;
#(
   parameter int unsigned PIPE_SPEED = DefPipeSpeed,
   parameter int unsigned PIPE_WRAP  = DefPipeWrap,
   parameter int unsigned GRAVITY    = DefGravity,
   parameter int unsigned FLAP_VEL   = DefFlapVel,
   parameter int unsigned MAX_FALL   = DefMaxFall,
   parameter int unsigned BIRD_MIN   = DefBirdMin,
   parameter int unsigned BIRD_MAX   = DefBirdMax,
   parameter int unsigned BIRD_START = DefBirdStart,
   parameter int unsigned SCORE_POS  = DefScorePos,
   parameter int unsigned DEAD_HOLD  = DefDeadHold
) (
   input logic               dclk,
   input logic               clr,
   flappy_game_ctrl_if.slave bus
);

   localparam int unsigned DcntW = $clog2(DEAD_HOLD + 1);

   localparam logic signed [7:0]  Grav     = 8'(GRAVITY);
   localparam logic signed [7:0]  FlapV    = 8'(FLAP_VEL);
   localparam logic signed [7:0]  VelFloor = 8'(0 - int'(MAX_FALL));
   localparam logic signed [10:0] BirdMaxS = 11'(BIRD_MAX);
   localparam logic signed [10:0] BirdMinS = 11'(BIRD_MIN);
   localparam logic signed [10:0] TopRef   = 11'(GroundY - 2 * BirdHalfH);
   localparam logic signed [10:0] BotRef   = 11'(GroundY);
   localparam logic signed [10:0] GapTopS  = 11'(GapTopOff);
   localparam logic signed [10:0] GapBotS  = 11'(GapBotOff);

   game_state_e       st_q, st_d;
   logic [9:0]        bird_q, bird_d;
   logic signed [7:0] vel_q, vel_d;
   logic [8:0]        pos_q, pos_d;
   logic [7:0]        pa0_q, pa0_d;
   logic [7:0]        pa1_q, pa1_d;
   logic [3:0]        score_q, score_d;
   logic              over_q, over_d;
   logic              pend_q, pend_d;
   logic [DcntW-1:0]  dcnt_q, dcnt_d;

   logic [6:0]         rnd;
   logic               flap_eff;
   logic signed [7:0]  vel_dec, vel_new;
   logic signed [10:0] nb;
   logic [9:0]         bird_new;
   logic               fall_dead;
   logic [9:0]         np;
   logic [8:0]         pos_new;
   logic [7:0]         pa0_new, pa1_new;
   logic [3:0]         score_new;
   logic signed [10:0] top, bot, gap_top, gap_bot;
   logic               hit;

   flappy_lfsr u_lfsr (
      .dclk (dclk),
      .clr  (clr),
      .rnd  (rnd)
   );

   // A flap arriving on the tick cycle itself applies to that tick.
   assign flap_eff = pend_q | bus.flap;

   // One frame of physics, evaluated every cycle and committed only on a PLAY tick.
   always_comb begin
      vel_dec = vel_q - Grav;
      if (flap_eff) begin
         vel_new = FlapV;
      end else if (vel_dec < VelFloor) begin
         vel_new = VelFloor;
      end else begin
         vel_new = vel_dec;
      end

      nb        = $signed({1'b0, bird_q}) + $signed({{3{vel_new[7]}}, vel_new});
      fall_dead = 1'b0;
      if (nb > BirdMaxS) begin
         bird_new = 10'(BIRD_MAX);
      end else if (nb < BirdMinS) begin
         bird_new  = 10'(BIRD_MIN);
         fall_dead = 1'b1;
      end else begin
         bird_new = nb[9:0];
      end

      np      = {1'b0, pos_q} + 10'(PIPE_SPEED);
      pos_new = np[8:0];
      pa0_new = pa0_q;
      pa1_new = pa1_q;
      if (np >= 10'(PIPE_WRAP)) begin
         pos_new = 9'(np - 10'(PIPE_WRAP));
         pa0_new = pa1_q;
         pa1_new = {1'b0, rnd} + 8'(GapBase);
      end

      // Score on the unwrapped position so a crossing right at the wrap still counts.
      score_new = score_q;
      if (({1'b0, pos_q} < 10'(SCORE_POS)) && (np >= 10'(SCORE_POS)) &&
          (score_q != 4'(ScoreMax))) begin
         score_new = score_q + 4'd1;
      end

      // Screen-space (y down) edges of the bird and of the gap in pipe0.
      top     = TopRef - $signed({1'b0, bird_new});
      bot     = BotRef - $signed({1'b0, bird_new});
      gap_top = $signed({3'b000, pa0_new}) + GapTopS;
      gap_bot = $signed({3'b000, pa0_new}) + GapBotS;
      hit     = (pos_new > 9'(HitPosLo)) && (pos_new < 9'(HitPosHi)) &&
                ((top <= gap_top) || (bot >= gap_bot));
   end

   always_comb begin
      st_d    = st_q;
      bird_d  = bird_q;
      vel_d   = vel_q;
      pos_d   = pos_q;
      pa0_d   = pa0_q;
      pa1_d   = pa1_q;
      score_d = score_q;
      dcnt_d  = dcnt_q;
      pend_d  = pend_q | bus.flap;

      if (bus.frame_tick) begin
         // Every tick consumes the pending flap, whether or not it is used.
         pend_d = 1'b0;
         unique case (st_q)
            StIdle: begin
               if (flap_eff) begin
                  st_d = StPlay;
               end
            end
            StPlay: begin
               vel_d   = vel_new;
               bird_d  = bird_new;
               pos_d   = pos_new;
               pa0_d   = pa0_new;
               pa1_d   = pa1_new;
               score_d = score_new;
               if (fall_dead || hit) begin
                  st_d = StDead;
               end
            end
            StDead: begin
               if (dcnt_q == DcntW'(DEAD_HOLD)) begin
                  if (flap_eff) begin
                     st_d    = StIdle;
                     bird_d  = 10'(BIRD_START);
                     vel_d   = '0;
                     pos_d   = '0;
                     pa0_d   = 8'(ResetGap);
                     pa1_d   = 8'(ResetGap);
                     score_d = '0;
                     dcnt_d  = '0;
                  end
               end else begin
                  dcnt_d = dcnt_q + DcntW'(1);
               end
            end
            default: st_d = StIdle;
         endcase
      end

      over_d = (st_d == StDead);
   end

   always_ff @(posedge dclk) begin
      if (clr) begin
         st_q    <= StIdle;
         bird_q  <= 10'(BIRD_START);
         vel_q   <= '0;
         pos_q   <= '0;
         pa0_q   <= 8'(ResetGap);
         pa1_q   <= 8'(ResetGap);
         score_q <= '0;
         over_q  <= 1'b0;
         pend_q  <= 1'b0;
         dcnt_q  <= '0;
      end else begin
         st_q    <= st_d;
         bird_q  <= bird_d;
         vel_q   <= vel_d;
         pos_q   <= pos_d;
         pa0_q   <= pa0_d;
         pa1_q   <= pa1_d;
         score_q <= score_d;
         over_q  <= over_d;
         pend_q  <= pend_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign bus.bird_coord    = bird_q;
   assign bus.pipe_pos      = pos_q;
   assign bus.pipe_array0   = pa0_q;
   assign bus.pipe_array1   = pa1_q;
   assign bus.current_score = score_q;
   assign bus.game_over     = over_q;

endmodule
